// File: rtl/output_writeback.sv
// output_writeback: streams LEN words from the output buffer (addresses 0..LEN-1)
// into the share buffer starting at a captured base address. The two-entry
// holding FIFO is formed by the registered share-write head plus one skid slot.
module output_writeback #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 13
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic [ADDR_W-1:0] OADDR,
  input  logic [5:0]        LEN,
  input  logic              SHARE_GNT,
  output logic              output_wen,
  output logic              output_ren,
  output logic              output_cen,
  output logic [ADDR_W-1:0] output_addr,
  input  logic [DATA_W-1:0] output_rdata,
  output logic              share_wen,
  output logic              share_ren,
  output logic              share_cen,
  output logic [ADDR_W-1:0] share_addr,
  output logic [DATA_W-1:0] share_wdata,
  output logic              BUSY,
  output logic              DONE
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  // control triples {wen, ren, cen}
  localparam logic [2:0] TRI_IDLE = 3'b101;
  localparam logic [2:0] TRI_RD   = 3'b110;
  localparam logic [2:0] TRI_WR   = 3'b011;

  function automatic logic [2:0] tri_enc(input logic rd, input logic wr);
    logic [2:0] t;
    if (wr) begin
      t = TRI_WR;
    end else if (rd) begin
      t = TRI_RD;
    end else begin
      t = TRI_IDLE;
    end
    return t;
  endfunction

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [5:0]          len_q, len_d;
  logic [5:0]          rcnt_q, rcnt_d;      // reads issued
  logic [5:0]          wcnt_q, wcnt_d;      // share writes accepted
  logic                pend_q, pend_d;      // read data arrives on output_rdata this cycle
  logic                hd_vld_q, hd_vld_d;  // FIFO head == presented share write
  logic [DATA_W-1:0]   hd_data_q, hd_data_d;
  logic                sk_vld_q, sk_vld_d;  // FIFO second entry
  logic [DATA_W-1:0]   sk_data_q, sk_data_d;
  logic [ADDR_W-1:0]   oaddr_q, oaddr_d;
  logic [ADDR_W-1:0]   saddr_q, saddr_d;
  logic [2:0]          out_tri_q, out_tri_d;
  logic [2:0]          sh_tri_q, sh_tri_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                rd_d;
  logic                rd_now;
  logic                accept;
  logic [1:0]          occ;

  assign rd_now = (out_tri_q == TRI_RD);

  assign {output_wen, output_ren, output_cen} = out_tri_q;
  assign {share_wen, share_ren, share_cen}    = sh_tri_q;
  assign output_addr = oaddr_q;
  assign share_addr  = saddr_q;
  assign share_wdata = hd_data_q;
  assign BUSY        = busy_q;
  assign DONE        = done_q;

  // Next-state: FIFO pop/push, read throttling, FSM sequencing and output values.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    len_d     = len_q;
    rcnt_d    = rcnt_q;
    wcnt_d    = wcnt_q;
    hd_vld_d  = hd_vld_q;
    hd_data_d = hd_data_q;
    sk_vld_d  = sk_vld_q;
    sk_data_d = sk_data_q;
    oaddr_d   = oaddr_q;
    saddr_d   = saddr_q;
    pend_d    = rd_now;
    rd_d      = 1'b0;
    accept    = hd_vld_q & SHARE_GNT;

    // pop the head when its write is granted
    if (accept) begin
      hd_vld_d  = sk_vld_q;
      hd_data_d = sk_data_q;
      sk_vld_d  = 1'b0;
      wcnt_d    = wcnt_q + 6'd1;
    end else begin
      wcnt_d    = wcnt_q;
    end

    // push the word read last cycle behind whatever remains
    if (pend_q) begin
      if (hd_vld_d) begin
        sk_vld_d  = 1'b1;
        sk_data_d = output_rdata;
      end else begin
        hd_vld_d  = 1'b1;
        hd_data_d = output_rdata;
      end
    end else begin
      sk_vld_d = sk_vld_d;
    end

    // entries held after this edge plus the read whose data lands next cycle
    occ = {1'b0, hd_vld_d} + {1'b0, sk_vld_d} + {1'b0, rd_now};

    case (state_q)
      IDLE: begin
        if (START) begin
          base_d = OADDR;
          len_d  = LEN;
          rcnt_d = 6'd0;
          wcnt_d = 6'd0;
          if (LEN == 6'd0) begin
            state_d = FIN;
          end else begin
            state_d = XFER;
          end
        end else begin
          state_d = IDLE;
        end
      end
      XFER: begin
        if (rcnt_q == len_q) begin
          state_d = DRAIN;
        end else if (occ < 2'd2) begin
          rd_d    = 1'b1;
          oaddr_d = ADDR_W'(rcnt_q);
          rcnt_d  = rcnt_q + 6'd1;
        end else begin
          rd_d = 1'b0;
        end
      end
      DRAIN: begin
        if (accept && ((wcnt_q + 6'd1) == len_q)) begin
          state_d = FIN;
        end else begin
          state_d = DRAIN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // head address follows the accepted-write count, so it holds while stalled
    if (state_d != IDLE) begin
      saddr_d = base_d + ADDR_W'(wcnt_d);
    end else begin
      saddr_d = saddr_q;
    end

    out_tri_d = tri_enc(rd_d, 1'b0);
    sh_tri_d  = tri_enc(1'b0, hd_vld_d);
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == FIN);
  end

  // State and registered outputs; reset aborts any transfer immediately.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      base_q    <= '0;
      len_q     <= 6'd0;
      rcnt_q    <= 6'd0;
      wcnt_q    <= 6'd0;
      pend_q    <= 1'b0;
      hd_vld_q  <= 1'b0;
      hd_data_q <= '0;
      sk_vld_q  <= 1'b0;
      sk_data_q <= '0;
      oaddr_q   <= '0;
      saddr_q   <= '0;
      out_tri_q <= TRI_IDLE;
      sh_tri_q  <= TRI_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      len_q     <= len_d;
      rcnt_q    <= rcnt_d;
      wcnt_q    <= wcnt_d;
      pend_q    <= pend_d;
      hd_vld_q  <= hd_vld_d;
      hd_data_q <= hd_data_d;
      sk_vld_q  <= sk_vld_d;
      sk_data_q <= sk_data_d;
      oaddr_q   <= oaddr_d;
      saddr_q   <= saddr_d;
      out_tri_q <= out_tri_d;
      sh_tri_q  <= sh_tri_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: doc/output_writeback.md
OUTPUT_WRITEBACK -- requirements
Module: output_writeback

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning the data word width of the output and share buffers.
REQ-002 SHALL have parameter ADDR_W, default 13, meaning the address width of both buffers.
REQ-003 SHALL have port CLK  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port START  input  1  one-cycle request to begin a writeback; sampled in IDLE only.
REQ-006 SHALL have port OADDR  input  ADDR_W  share-buffer base address; captured with START.
REQ-007 SHALL have port LEN  input  6  word count, 0..32; captured with START.
REQ-008 SHALL have port SHARE_GNT  input  1  share-buffer grant; a presented write is accepted only in a cycle where it is high.
REQ-009 SHALL have ports output_wen, output_ren, output_cen  output  1 each  output-buffer control.
REQ-010 SHALL have port output_addr  output  ADDR_W  output-buffer read address.
REQ-011 SHALL have port output_rdata  input  DATA_W  output-buffer read data, valid the cycle after a read is presented.
REQ-012 SHALL have ports share_wen, share_ren, share_cen  output  1 each  share-buffer control.
REQ-013 SHALL have port share_addr  output  ADDR_W  share-buffer write address.
REQ-014 SHALL have port share_wdata  output  DATA_W  share-buffer write data.
REQ-015 SHALL have ports BUSY and DONE  output  1 each  BUSY high outside IDLE; DONE is a one-cycle completion pulse.

Function
REQ-016 SHALL encode each buffer's control triple (wen,ren,cen) as idle=(1,0,1), read=(1,1,0), write=(0,1,1); no other combination is driven.
REQ-017 SHALL register all outputs.
REQ-018 SHALL implement states IDLE, XFER, DRAIN, FIN.
REQ-019 SHALL, in IDLE, on START with LEN!=0, capture OADDR and LEN and enter XFER; with LEN==0, go to FIN directly, with no buffer access.
REQ-020 SHALL, in XFER, present output-buffer reads at addresses 0,1,...,LEN-1 in order, one per cycle, when not throttled.
REQ-021 SHALL capture output_rdata into a 2-entry holding FIFO the cycle after each read, and present the FIFO head as a share write at share_addr = base + i, modulo 2^ADDR_W (wrap-around).
REQ-022 SHALL, absent stalls, present the share write of word i exactly 2 cycles after the output read of word i.
REQ-023 SHALL issue a new read only when FIFO occupancy plus reads in flight is below 2; no word is ever dropped or duplicated.
REQ-024 SHALL, when SHARE_GNT is low, hold share_addr, share_wdata and the write triple unchanged until a cycle with SHARE_GNT high.
REQ-025 SHALL, after the last read is issued, enter DRAIN, drive the output-buffer triple to idle, and remain in DRAIN until the FIFO empties.
REQ-026 SHALL, when the last share write is accepted, drive the share triple to idle on the next cycle and enter FIN.
REQ-027 SHALL, in FIN, assert DONE for exactly one cycle and return to IDLE; BUSY falls in the same cycle.
REQ-028 SHALL ignore START whenever it is not in IDLE.
REQ-029 SHALL drive share_ren from the same rule as the other triples; it never reads the share buffer.

Reset
REQ-030 SHALL, on RESET high, immediately set state IDLE, all triples to idle (1,0,1), all addresses and share_wdata to 0, FIFO empty, and BUSY=DONE=0.
REQ-031 SHALL, on RESET mid-transfer, abort with no DONE pulse; the next START after release begins a fresh transfer at word 0.

Verification
REQ-032 Verification SHALL cover: LEN=31, OADDR=0x100, SHARE_GNT=1, output word k = k+0xA000 -> share addresses 0x100..0x11E receive 0xA000..0xA01E, with a 2-cycle read-to-write delay and a DONE pulse the cycle after the last write is accepted.
REQ-033 Verification SHALL cover: LEN=4, with SHARE_GNT low for 5 cycles during word 1 -> all 4 words written once, in order; write held stable while stalled; at most 2 reads ahead.
REQ-034 Verification SHALL cover: OADDR=0x1FFE, LEN=4 -> share writes to 0x1FFE, 0x1FFF, 0x0000, 0x0001.
REQ-035 Verification SHALL cover: LEN=0 -> no buffer access; DONE pulses once; returns to IDLE.
REQ-036 Verification SHALL cover: START re-pulsed mid-transfer -> ignored; RESET asserted at word 2 -> outputs at reset values immediately, no DONE; a new START with LEN=2 completes correctly.
